vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator for the 800x600 VGA path.
- Runs from the 50 MHz pixel clock.
- Produces hsync/vsync plus the x_pos, y_pos and display_enable that drive the downstream SRAM-backed colour stage.
- Default timing is VESA 800x600@72 Hz; all horizontal and vertical intervals are parameters.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 56, horizontal front porch (clocks)
- H_SYNC, 120, horizontal sync width (clocks)
- H_BP, 64, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 37, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)

Ports:
- clk  input  1  pixel clock, 50 MHz, rising edge
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run control; low holds raster at origin
- hsync  output  1  horizontal sync, polarity SYNC_POL
- vsync  output  1  vertical sync, polarity SYNC_POL
- display_enable  output  1  high during the visible region
- x_pos  output  10  visible column 0..H_ACTIVE-1, else 0
- y_pos  output  10  visible line 0..V_ACTIVE-1, else 0
- line_start  output  1  one-clock pulse at h=0 of every line
- frame_start  output  1  one-clock pulse at h=0, v=0
- frame_count  output  8  frames started, wraps 255->0

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Internal counters:
  - h_cnt is 11 bits, range 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1040).
  - v_cnt is 10 bits, range 0..V_TOTAL-1 (default 666).
- Reset (rst_n low, asynchronous):
  - h_cnt = 0, v_cnt = 0, frame_count = 0.
  - display_enable, x_pos, y_pos, line_start, frame_start = 0.
  - hsync and vsync = ~SYNC_POL (inactive).
- Counting: each rising edge with enable = 1:
  - If h_cnt == H_TOTAL-1: h_cnt <= 0, and v_cnt advances (v_cnt == V_TOTAL-1 wraps to 0).
  - Otherwise h_cnt <= h_cnt + 1.
- Output decode: all outputs are registered decodes of the current (h_cnt, v_cnt), so they lag the counters by exactly 1 clock and are mutually aligned.
  - display_enable = (h < H_ACTIVE) && (v < V_ACTIVE).
  - x_pos = h[9:0] when h < H_ACTIVE, else 0. y_pos = v when v < V_ACTIVE, else 0. Downstream addr = 800*y+x therefore never exceeds 479999.
  - hsync is active for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (default 856..975).
  - vsync is active for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (default 637..642). vsync changes on the same clock as h wrapping to 0.
  - line_start = (h == 0). frame_start = (h == 0 && v == 0).
  - frame_count increments on the same edge that registers frame_start = 1.
- enable low:
  - On the next edge, h_cnt = v_cnt = 0; counters hold while enable stays low.
  - Outputs register their idle state: syncs inactive, display_enable/line_start/frame_start = 0, x_pos = y_pos = 0.
  - frame_count holds.
- enable rising: the first edge with enable = 1 registers outputs for (0,0), i.e. frame_start = 1, line_start = 1, display_enable = 1, x = y = 0. frame_count increments on that edge.
- enable deasserted mid-frame: the raster aborts with no partial-frame completion; the restart is a clean new frame.
- Reset mid-frame: immediate return to reset values. After rst_n deasserts with enable = 1, the first edge behaves exactly as the enable-rising case.
- Timing per frame: 1040*666 = 692640 clocks.

Test Plan:
- Reset release, enable = 1:
  - Edge 1: frame_start = 1, line_start = 1, display_enable = 1, x_pos = 0, y_pos = 0, frame_count = 1, hsync = vsync = 0.
  - Edge 800: x_pos = 799, display_enable = 1.
  - Edge 801: display_enable = 0, x_pos = 0.
- Horizontal sync window, line 0: hsync = 1 on edges 857..976 exactly (120 clocks); line_start re-pulses on edge 1041 with y_pos = 1.
- Vertical sync window: vsync high for exactly 6*1040 = 6240 clocks, starting at the edge registering v = 637, h = 0. display_enable = 0 for all lines 600..665.
- Frame wrap: second frame_start occurs 692640 clocks after the first. frame_count counts 1, 2, ...; forcing 256 frames (short-parameter build, e.g. H_TOTAL = 8, V_TOTAL = 4) gives frame_count wrap 255 -> 0.
- enable dropped at h = 400, v = 300:
  - Next edge: all outputs idle, x_pos = y_pos = 0.
  - Re-enable after 10 clocks: first edge gives frame_start = 1 at (0,0); frame_count increments once.
- Async reset asserted mid-line (h = 900, hsync = 1): outputs go to reset values without waiting for a clock edge, hsync = 0 immediately, frame_count = 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered sync,
// visible-region and position decodes, plus line/frame markers and a frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned SYNC_POL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       display_enable,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_W      = 11;
  localparam int unsigned V_W      = 10;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        SYNC_ON  = 1'(SYNC_POL);

  logic [H_W-1:0] h_cnt;
  logic [V_W-1:0] v_cnt;

  logic       h_vis_c;
  logic       v_vis_c;
  logic       hs_act_c;
  logic       vs_act_c;
  logic       line_start_c;
  logic       frame_start_c;
  logic [9:0] x_c;
  logic [9:0] y_c;

  // Raster counters; enable low parks the raster at the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_W'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      if (v_cnt == V_W'(V_TOTAL - 1)) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + V_W'(1);
      end
    end else begin
      h_cnt <= h_cnt + H_W'(1);
    end
  end

  // Combinational decode of the current raster position.
  always_comb begin
    h_vis_c       = (h_cnt < H_W'(H_ACTIVE));
    v_vis_c       = (v_cnt < V_W'(V_ACTIVE));
    hs_act_c      = (h_cnt >= H_W'(HS_START)) && (h_cnt < H_W'(HS_END));
    vs_act_c      = (v_cnt >= V_W'(VS_START)) && (v_cnt < V_W'(VS_END));
    line_start_c  = (h_cnt == '0);
    frame_start_c = (h_cnt == '0) && (v_cnt == '0);
    x_c           = h_vis_c ? h_cnt[9:0] : 10'd0;
    y_c           = v_vis_c ? v_cnt : 10'd0;
  end

  // Registered outputs, all one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync          <= ~SYNC_ON;
      vsync          <= ~SYNC_ON;
      display_enable <= 1'b0;
      x_pos          <= '0;
      y_pos          <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
      frame_count    <= '0;
    end else if (!enable) begin
      hsync          <= ~SYNC_ON;
      vsync          <= ~SYNC_ON;
      display_enable <= 1'b0;
      x_pos          <= '0;
      y_pos          <= '0;
      line_start     <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      hsync          <= hs_act_c ? SYNC_ON : ~SYNC_ON;
      vsync          <= vs_act_c ? SYNC_ON : ~SYNC_ON;
      display_enable <= h_vis_c && v_vis_c;
      x_pos          <= x_c;
      y_pos          <= y_c;
      line_start     <= line_start_c;
      frame_start    <= frame_start_c;
      if (frame_start_c) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized enable/reset stimulus against an arithmetic raster model, on a
// short-timing inverted-polarity instance and a default-timing instance.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } exp_t;

  localparam int SHA = 10, SHF = 2, SHS = 3, SHB = 2;
  localparam int SVA = 6,  SVF = 1, SVS = 2, SVB = 1;

  logic clk, rst_n, enable;

  logic       a_hs, a_vs, a_de, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_hs, b_vs, b_de, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;

  int checks = 0;
  int errors = 0;

  int         ta, tb_t;
  exp_t       ea, eb;
  logic [7:0] fca, fcb;

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SYNC_POL(0)
  ) u_short (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hsync(a_hs), .vsync(a_vs), .display_enable(a_de),
    .x_pos(a_x), .y_pos(a_y), .line_start(a_ls), .frame_start(a_fs),
    .frame_count(a_fc)
  );

  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hsync(b_hs), .vsync(b_vs), .display_enable(b_de),
    .x_pos(b_x), .y_pos(b_y), .line_start(b_ls), .frame_start(b_fs),
    .frame_count(b_fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_out(input bit pol);
    exp_t r;
    r    = '0;
    r.hs = !pol;
    r.vs = !pol;
    return r;
  endfunction

  // Expected outputs for the t-th enabled clock since the raster left the origin.
  function automatic exp_t ref_out(input int t, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input bit pol);
    exp_t r;
    int ht, vt, h, v;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = t % ht;
    v    = (t / ht) % vt;
    r.de = (h < ha) && (v < va);
    r.x  = (h < ha) ? 10'(h) : 10'd0;
    r.y  = (v < va) ? 10'(v) : 10'd0;
    r.hs = ((h >= ha + hf) && (h < ha + hf + hs)) ? pol : !pol;
    r.vs = ((v >= va + vf) && (v < va + vf + vs)) ? pol : !pol;
    r.ls = (h == 0);
    r.fs = (h == 0) && (v == 0);
    return r;
  endfunction

  task automatic compare_all();
    check("a_hsync", 32'(a_hs), 32'(ea.hs));
    check("a_vsync", 32'(a_vs), 32'(ea.vs));
    check("a_de",    32'(a_de), 32'(ea.de));
    check("a_x",     32'(a_x),  32'(ea.x));
    check("a_y",     32'(a_y),  32'(ea.y));
    check("a_ls",    32'(a_ls), 32'(ea.ls));
    check("a_fs",    32'(a_fs), 32'(ea.fs));
    check("a_fc",    32'(a_fc), 32'(fca));
    check("b_hsync", 32'(b_hs), 32'(eb.hs));
    check("b_vsync", 32'(b_vs), 32'(eb.vs));
    check("b_de",    32'(b_de), 32'(eb.de));
    check("b_x",     32'(b_x),  32'(eb.x));
    check("b_y",     32'(b_y),  32'(eb.y));
    check("b_ls",    32'(b_ls), 32'(eb.ls));
    check("b_fs",    32'(b_fs), 32'(eb.fs));
    check("b_fc",    32'(b_fc), 32'(fcb));
  endtask

  task automatic model_reset();
    ta   = 0;
    tb_t = 0;
    ea   = idle_out(1'b0);
    eb   = idle_out(1'b1);
    fca  = 8'd0;
    fcb  = 8'd0;
  endtask

  task automatic model_step();
    if (enable) begin
      ea = ref_out(ta, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1'b0);
      eb = ref_out(tb_t, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1);
      ta++;
      tb_t++;
      if (ea.fs) fca = fca + 8'd1;
      if (eb.fs) fcb = fcb + 8'd1;
    end else begin
      ta   = 0;
      tb_t = 0;
      ea   = idle_out(1'b0);
      eb   = idle_out(1'b1);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    enable = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 compare_all();

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Phase 1: random enable drops and asynchronous resets mid-line.
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
      if (enable) begin
        if ($urandom_range(0, 49) == 0) enable = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) enable = 1'b1;
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        enable = $urandom_range(0, 1) != 0;
        #1 rst_n = 1'b1;
      end
    end

    // Phase 2: steady run, long enough for the short-timing frame counter to wrap.
    enable = 1'b1;
    for (int i = 0; i < 44000; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
